addr_scan_ctrl: RTL and testbench
=================================

ADDR_SCAN_CTRL -- requirements
Module: addr_scan_ctrl

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- WORD_W, 7, word-address width per bank.
- DEPTH, 128, words per bank; 2 <= DEPTH <= 2^WORD_W.
- BANK_W, 1, bank-select width.
- NUM_BANKS, 2, banks scanned; 1 <= NUM_BANKS <= 2^BANK_W.
- TICK_BASE, 250, clock cycles per advance at level 0; >= 2.
- DB_CYCLES, 4, debounce stability window in cycles; >= 1.
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk, in, 1, single clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- pause, in, 1, button, high when pressed; asynchronous.
- speedup, in, 1, button; asynchronous.
- speeddown, in, 1, button; asynchronous.
- step, in, 1, button, single advance while paused; asynchronous.
- reverse, in, 1, level; 1 = scan downward; asynchronous.
- addr, out, BANK_W+WORD_W, {bank, word}.
- paused, out, 1, high while scanning is frozen.
- speed_level, out, 3, current level 0..4.
- advance, out, 1, one-cycle pulse on each addr change.
- wrap, out, 1, one-cycle pulse when bank passes between last and 0.

Function
REQ-003 Each of the 5 inputs SHALL pass through a 2-flop synchroniser before use.
REQ-004 Each button SHALL have a debounced level that takes the synchronised value only after DB_CYCLES consecutive cycles of disagreement; any agreeing cycle restarts the count.
REQ-005 A press event SHALL be the one-cycle rising edge of a debounced level; releases generate no event.
REQ-006 reverse SHALL use the synchronised value directly, with no debounce.
REQ-007 Speed level SHALL be 0..4; period = TICK_BASE << level cycles; level 2 is nominal.
REQ-008 A speedup event SHALL decrement level, saturating at 0; a speeddown event SHALL increment level, saturating at 4.
REQ-009 Simultaneous speedup and speeddown events SHALL be ignored.
REQ-010 Any level change SHALL clear the tick counter in the same cycle.
REQ-011 A pause event SHALL toggle paused.
REQ-012 While paused, the tick counter SHALL hold its value.
REQ-013 On resume, counting SHALL continue from the held value.
REQ-014 While running, the tick counter SHALL count 0..period-1.
REQ-015 On the cycle the tick counter equals period-1, it SHALL return to 0 and one advance SHALL occur on the next clock edge.
REQ-016 A step event while paused SHALL cause exactly one advance.
REQ-017 A step event while running SHALL be ignored.
REQ-018 If a step and a pause event occur in the same cycle, pause SHALL be applied first and step evaluated against the new paused state.
REQ-019 Forward advance: word+1. If word was DEPTH-1: word=0 and bank+1; from bank NUM_BANKS-1, bank=0 and wrap pulses.
REQ-020 Reverse advance: word-1. If word was 0: word=DEPTH-1 and bank-1; from bank 0, bank=NUM_BANKS-1 and wrap pulses.
REQ-021 advance and wrap SHALL be registered and coincident with the addr update.
REQ-022 addr SHALL never leave {0..NUM_BANKS-1} x {0..DEPTH-1}.
REQ-023 A change in reverse SHALL take effect at the next advance without disturbing the tick counter.

Reset
REQ-024 rst_n low SHALL asynchronously force the following:
- addr=0, paused=0, speed_level=2, advance=0, wrap=0.
- Tick counter, synchronisers, debounce counters and debounced levels all 0.
REQ-025 Reset asserted mid-scan or mid-debounce SHALL discard all pending events.
REQ-026 After rst_n deasserts, the first advance SHALL occur 4*TICK_BASE cycles later.

Verification
REQ-027 A bench SHALL cover the following directed scenarios; TICK_BASE=4, DB_CYCLES=4, DEPTH=5, NUM_BANKS=3:
- Free run from reset: advance every 16 cycles; sequence {0,0}..{0,4},{1,0}..{2,4},{0,0}; wrap pulses once at {2,4}->{0,0}.
- Three speedup presses: level 2->1->0->0; period 16->8->4; tick counter cleared at each change.
- Button glitch high for 3 cycles: no event. Held 20 cycles: exactly one event.
- Pause, then 2 step presses: addr advances by exactly 2. A step while running: no change. Pause again: resumes with the held counter.
- reverse=1 at {0,0}: next advance gives {2,4} with a wrap pulse.
- rst_n low while at {1,3}, level 0, paused: addr=0, level 2 and paused=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/addr_scan_ctrl.sv
// rtl/addr_scan_ctrl.sv - banked address scanner with debounced pause/step/speed controls

// Debounces one synchronised button level and emits a one-cycle press pulse
module addr_scan_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic [DB_W-1:0] cnt;
  logic            level_d;

  // Level follows din only after DB_CYCLES consecutive disagreeing cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
    end else begin
      level_d <= level;
      if (din == level) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        level <= din;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Only the press edge is an event; releases are silent
  always_comb begin
    rise = level & ~level_d;
  end

endmodule

// Scans {bank, word} addresses at a selectable rate, with pause/step and direction
module addr_scan_ctrl #(
  parameter int WORD_W    = 7,
  parameter int DEPTH     = 128,
  parameter int BANK_W    = 1,
  parameter int NUM_BANKS = 2,
  parameter int TICK_BASE = 250,
  parameter int DB_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pause,
  input  logic                     speedup,
  input  logic                     speeddown,
  input  logic                     step,
  input  logic                     reverse,
  output logic [BANK_W+WORD_W-1:0] addr,
  output logic                     paused,
  output logic [2:0]               speed_level,
  output logic                     advance,
  output logic                     wrap
);

  // Longest period is TICK_BASE << 4; the counter only ever reaches period-1
  localparam int CNT_W = $clog2(TICK_BASE * 16);
  localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(DEPTH - 1);
  localparam logic [BANK_W-1:0] BANK_LAST = BANK_W'(NUM_BANKS - 1);
  localparam logic [2:0]        LVL_MIN   = 3'd0;
  localparam logic [2:0]        LVL_MAX   = 3'd4;
  localparam logic [2:0]        LVL_RESET = 3'd2;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } run_state_t;

  // Input bit order: {reverse, step, speeddown, speedup, pause}
  logic [4:0]        raw_in;
  logic [4:0]        sync1;
  logic [4:0]        sync2;
  logic [3:0]        btn_level;
  logic [3:0]        btn_press;

  logic              pause_ev;
  logic              up_ev;
  logic              down_ev;
  logic              step_ev;
  logic              rev;

  run_state_t        state;
  run_state_t        state_next;
  logic              paused_next;

  logic [2:0]        level_next;
  logic              level_change;

  logic [CNT_W-1:0]  tick_cnt;
  logic [CNT_W-1:0]  period_m1;
  logic              period_end;
  logic              tick_adv;
  logic              step_adv;
  logic              do_adv;

  logic [WORD_W-1:0] word;
  logic [BANK_W-1:0] bank;
  logic [WORD_W-1:0] word_next;
  logic [BANK_W-1:0] bank_next;
  logic              wrap_next;

  assign raw_in = {reverse, step, speeddown, speedup, pause};

  // Two-flop synchroniser on every asynchronous input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_btn
      addr_scan_debounce #(
        .DB_CYCLES(DB_CYCLES)
      ) u_db (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (sync2[gi]),
        .level(btn_level[gi]),
        .rise (btn_press[gi])
      );
    end
  endgenerate

  assign pause_ev = btn_press[0];
  assign up_ev    = btn_press[1];
  assign down_ev  = btn_press[2];
  assign step_ev  = btn_press[3];
  // Direction is a level, so it bypasses the debouncer
  assign rev      = sync2[4];

  // Run/hold state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Each pause press flips between running and frozen
  always_comb begin
    state_next = state;
    if (pause_ev) begin
      state_next = (state == RUN) ? HOLD : RUN;
    end
  end

  // Run/hold outputs; step is judged against the post-pause state
  always_comb begin
    paused      = (state == HOLD);
    paused_next = (state_next == HOLD);
  end

  // Saturating speed level; opposing presses in one cycle cancel
  always_comb begin
    level_next = speed_level;
    if (up_ev && !down_ev && speed_level != LVL_MIN) begin
      level_next = speed_level - 3'd1;
    end else if (down_ev && !up_ev && speed_level != LVL_MAX) begin
      level_next = speed_level + 3'd1;
    end
    level_change = (level_next != speed_level);
  end

  // Speed level register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      speed_level <= LVL_RESET;
    end else begin
      speed_level <= level_next;
    end
  end

  // Advance requests: a level change restarts the period and suppresses that tick
  always_comb begin
    period_m1  = CNT_W'((TICK_BASE << speed_level) - 1);
    period_end = !paused && (tick_cnt == period_m1);
    tick_adv   = period_end && !level_change;
    step_adv   = step_ev && paused_next;
    do_adv     = tick_adv || step_adv;
  end

  // Tick counter: cleared on level change, frozen while paused, else 0..period-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (level_change) begin
      tick_cnt <= '0;
    end else if (paused) begin
      tick_cnt <= tick_cnt;
    end else if (period_end) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Next address in the current direction, flagging a bank wrap
  always_comb begin
    word_next = word;
    bank_next = bank;
    wrap_next = 1'b0;
    if (!rev) begin
      if (word == WORD_LAST) begin
        word_next = '0;
        if (bank == BANK_LAST) begin
          bank_next = '0;
          wrap_next = 1'b1;
        end else begin
          bank_next = bank + 1'b1;
        end
      end else begin
        word_next = word + 1'b1;
      end
    end else begin
      if (word == '0) begin
        word_next = WORD_LAST;
        if (bank == '0) begin
          bank_next = BANK_LAST;
          wrap_next = 1'b1;
        end else begin
          bank_next = bank - 1'b1;
        end
      end else begin
        word_next = word - 1'b1;
      end
    end
  end

  // Address update with coincident advance/wrap pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word    <= '0;
      bank    <= '0;
      advance <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      advance <= do_adv;
      wrap    <= do_adv && wrap_next;
      if (do_adv) begin
        word <= word_next;
        bank <= bank_next;
      end
    end
  end

  assign addr = {bank, word};

endmodule

// File: tb/tb_addr_scan_ctrl.sv
// tb/tb_addr_scan_ctrl.sv - directed bench for addr_scan_ctrl
module tb_addr_scan_ctrl;

  localparam int WORD_W    = 3;
  localparam int DEPTH     = 5;
  localparam int BANK_W    = 2;
  localparam int NUM_BANKS = 3;
  localparam int TICK_BASE = 4;
  localparam int DB_CYCLES = 4;

  logic       clk;
  logic       rst_n;
  logic       pause;
  logic       speedup;
  logic       speeddown;
  logic       step;
  logic       reverse;
  logic [4:0] addr;
  logic       paused;
  logic [2:0] speed_level;
  logic       advance;
  logic       wrap;

  int n_pass     = 0;
  int n_total    = 0;
  int adv_total  = 0;
  int wrap_total = 0;

  addr_scan_ctrl #(
    .WORD_W   (WORD_W),
    .DEPTH    (DEPTH),
    .BANK_W   (BANK_W),
    .NUM_BANKS(NUM_BANKS),
    .TICK_BASE(TICK_BASE),
    .DB_CYCLES(DB_CYCLES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pause      (pause),
    .speedup    (speedup),
    .speeddown  (speeddown),
    .step       (step),
    .reverse    (reverse),
    .addr       (addr),
    .paused     (paused),
    .speed_level(speed_level),
    .advance    (advance),
    .wrap       (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    if (advance === 1'b1) adv_total++;
    if (wrap === 1'b1) wrap_total++;
  endtask

  task automatic wait_adv(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (advance !== 1'b1 && n < 80);
  endtask

  task automatic wait_paused(input logic v, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (paused !== v && n < 40);
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0:       pause = v;
      1:       speedup = v;
      2:       speeddown = v;
      3:       step = v;
      default: reverse = v;
    endcase
  endtask

  task automatic press(input int b);
    set_btn(b, 1'b1);
    repeat (20) tick();
    set_btn(b, 1'b0);
    repeat (12) tick();
  endtask

  task automatic reset_to(input logic p, input logic r);
    rst_n = 1'b0;
    pause = 1'b0; speedup = 1'b0; speeddown = 1'b0; step = 1'b0; reverse = 1'b0;
    #20;
    @(negedge clk);
    pause   = p;
    reverse = r;
    rst_n   = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pause = 1'b0; speedup = 1'b0; speeddown = 1'b0; step = 1'b0; reverse = 1'b0;
    #23;
    n_total++; if (addr !== 5'd0) $display("FAIL reset_addr: got %0d expected 0", addr); else n_pass++;
    n_total++; if (paused !== 1'b0) $display("FAIL reset_paused: got %b expected 0", paused); else n_pass++;
    n_total++; if (speed_level !== 3'd2) $display("FAIL reset_level: got %0d expected 2", speed_level); else n_pass++;
    n_total++; if (advance !== 1'b0) $display("FAIL reset_advance: got %b expected 0", advance); else n_pass++;
    n_total++; if (wrap !== 1'b0) $display("FAIL reset_wrap: got %b expected 0", wrap); else n_pass++;
  endtask

  task automatic test_free_run();
    int n;
    int b;
    int w;
    int w0;
    logic [4:0] exp_addr;
    b = 0; w = 0;
    reset_to(1'b0, 1'b0);
    w0 = wrap_total;
    for (int a = 0; a < 15; a++) begin
      wait_adv(n);
      if (w == DEPTH - 1) begin
        w = 0;
        b = (b == NUM_BANKS - 1) ? 0 : b + 1;
      end else begin
        w = w + 1;
      end
      exp_addr = 5'(b * 8 + w);
      n_total++; if (n !== 16) $display("FAIL free_gap[%0d]: got %0d cycles expected 16", a, n); else n_pass++;
      n_total++; if (addr !== exp_addr) $display("FAIL free_addr[%0d]: got %0d expected %0d", a, addr, exp_addr); else n_pass++;
      n_total++; if (wrap !== (a == 14)) $display("FAIL free_wrap[%0d]: got %b expected %b", a, wrap, (a == 14)); else n_pass++;
    end
    n_total++; if (wrap_total - w0 !== 1) $display("FAIL free_wrap_count: got %0d expected 1", wrap_total - w0); else n_pass++;
  endtask

  task automatic test_speedup();
    int n;
    int m;
    logic [2:0] exp_lvl;
    for (int p = 0; p < 2; p++) begin
      exp_lvl = (p == 0) ? 3'd1 : 3'd0;
      speedup = 1'b1;
      n = 0;
      do begin
        tick();
        n++;
      end while (speed_level === ((p == 0) ? 3'd2 : 3'd1) && n < 30);
      n_total++; if (n !== 7) $display("FAIL speedup_latency[%0d]: got %0d expected 7", p, n); else n_pass++;
      n_total++; if (speed_level !== exp_lvl) $display("FAIL speedup_level[%0d]: got %0d expected %0d", p, speed_level, exp_lvl); else n_pass++;
      wait_adv(m);
      n_total++; if (m !== ((p == 0) ? 8 : 4)) $display("FAIL speedup_period[%0d]: got %0d expected %0d", p, m, (p == 0) ? 8 : 4); else n_pass++;
      repeat (20 - n - m) tick();
      speedup = 1'b0;
      repeat (12) tick();
    end
    press(1);
    n_total++; if (speed_level !== 3'd0) $display("FAIL speedup_saturate: got %0d expected 0", speed_level); else n_pass++;
    wait_adv(m);
    wait_adv(m);
    n_total++; if (m !== 4) $display("FAIL speedup_min_period: got %0d expected 4", m); else n_pass++;
  endtask

  task automatic test_glitch();
    speeddown = 1'b1;
    repeat (3) tick();
    speeddown = 1'b0;
    repeat (15) tick();
    n_total++; if (speed_level !== 3'd0) $display("FAIL glitch_ignored: got %0d expected 0", speed_level); else n_pass++;
    press(2);
    n_total++; if (speed_level !== 3'd1) $display("FAIL held_one_event: got %0d expected 1", speed_level); else n_pass++;
    press(2);
    n_total++; if (speed_level !== 3'd2) $display("FAIL speeddown_again: got %0d expected 2", speed_level); else n_pass++;
  endtask

  task automatic test_pause_step();
    int n;
    int m;
    int a0;
    reset_to(1'b1, 1'b0);
    a0 = adv_total;
    wait_paused(1'b1, n);
    n_total++; if (n !== 7) $display("FAIL pause_latency: got %0d expected 7", n); else n_pass++;
    repeat (20 - n) tick();
    pause = 1'b0;
    repeat (12) tick();
    n_total++; if (addr !== 5'd0) $display("FAIL paused_addr: got %0d expected 0", addr); else n_pass++;
    n_total++; if (adv_total - a0 !== 0) $display("FAIL paused_no_adv: got %0d expected 0", adv_total - a0); else n_pass++;
    for (int s = 0; s < 2; s++) begin
      step = 1'b1;
      wait_adv(n);
      n_total++; if (n !== 7) $display("FAIL step_latency[%0d]: got %0d expected 7", s, n); else n_pass++;
      n_total++; if (addr !== 5'(s + 1)) $display("FAIL step_addr[%0d]: got %0d expected %0d", s, addr, s + 1); else n_pass++;
      repeat (20 - n) tick();
      step = 1'b0;
      repeat (12) tick();
    end
    n_total++; if (adv_total - a0 !== 2) $display("FAIL step_count: got %0d expected 2", adv_total - a0); else n_pass++;
    pause = 1'b1;
    wait_paused(1'b0, n);
    n_total++; if (n !== 7) $display("FAIL resume_latency: got %0d expected 7", n); else n_pass++;
    wait_adv(m);
    n_total++; if (m !== 9) $display("FAIL resume_held_count: got %0d expected 9", m); else n_pass++;
    n_total++; if (addr !== 5'd3) $display("FAIL resume_addr: got %0d expected 3", addr); else n_pass++;
    step = 1'b1;
    wait_adv(m);
    n_total++; if (m !== 16) $display("FAIL step_running_gap: got %0d expected 16", m); else n_pass++;
    n_total++; if (addr !== 5'd4) $display("FAIL step_running_addr: got %0d expected 4", addr); else n_pass++;
    pause = 1'b0;
    step  = 1'b0;
    repeat (12) tick();
  endtask

  task automatic test_reverse();
    int n;
    reset_to(1'b0, 1'b1);
    wait_adv(n);
    n_total++; if (n !== 16) $display("FAIL rev_gap0: got %0d expected 16", n); else n_pass++;
    n_total++; if (addr !== 5'd20) $display("FAIL rev_wrap_addr: got %0d expected 20", addr); else n_pass++;
    n_total++; if (wrap !== 1'b1) $display("FAIL rev_wrap_pulse: got %b expected 1", wrap); else n_pass++;
    wait_adv(n);
    n_total++; if (n !== 16) $display("FAIL rev_gap1: got %0d expected 16", n); else n_pass++;
    n_total++; if (addr !== 5'd19) $display("FAIL rev_down_addr: got %0d expected 19", addr); else n_pass++;
    n_total++; if (wrap !== 1'b0) $display("FAIL rev_no_wrap: got %b expected 0", wrap); else n_pass++;
    reverse = 1'b0;
    wait_adv(n);
    n_total++; if (n !== 16) $display("FAIL rev_switch_gap: got %0d expected 16", n); else n_pass++;
    n_total++; if (addr !== 5'd20) $display("FAIL rev_switch_addr: got %0d expected 20", addr); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int n;
    int a0;
    reset_to(1'b1, 1'b0);
    wait_paused(1'b1, n);
    repeat (20 - n) tick();
    pause = 1'b0;
    repeat (12) tick();
    press(1);
    press(1);
    n_total++; if (speed_level !== 3'd0) $display("FAIL mid_level_setup: got %0d expected 0", speed_level); else n_pass++;
    a0 = adv_total;
    for (int s = 0; s < 8; s++) press(3);
    n_total++; if (addr !== 5'd11) $display("FAIL mid_addr_setup: got %0d expected 11", addr); else n_pass++;
    n_total++; if (adv_total - a0 !== 8) $display("FAIL mid_step_count: got %0d expected 8", adv_total - a0); else n_pass++;
    n_total++; if (paused !== 1'b1) $display("FAIL mid_paused_setup: got %b expected 1", paused); else n_pass++;
    speedup = 1'b1;
    repeat (4) tick();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_total++; if (addr !== 5'd0) $display("FAIL async_addr: got %0d expected 0", addr); else n_pass++;
    n_total++; if (speed_level !== 3'd2) $display("FAIL async_level: got %0d expected 2", speed_level); else n_pass++;
    n_total++; if (paused !== 1'b0) $display("FAIL async_paused: got %b expected 0", paused); else n_pass++;
    speedup = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_adv(n);
    n_total++; if (n !== 16) $display("FAIL post_reset_first_adv: got %0d expected 16", n); else n_pass++;
    n_total++; if (speed_level !== 3'd2) $display("FAIL post_reset_level: got %0d expected 2", speed_level); else n_pass++;
    n_total++; if (addr !== 5'd1) $display("FAIL post_reset_addr: got %0d expected 1", addr); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_speedup();
    test_glitch();
    test_pause_step();
    test_reverse();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
